// File: rtl/fft_frame_tx.sv
// Purpose: ping-pong frame buffer feeding the first FFT butterfly stage, optional conjugate on output.
// Latency: from IDLE, beat 0 appears two cycles after the edge accepting the last host beat of a frame.
// Backpressure: in_ready drops only while both banks hold full frames; the output side never stalls.
module fft_frame_tx #(
    parameter int WIDTH = 9,
    parameter int LANES = 16,
    parameter int BEATS = 32
) (
    input  logic                               clk,
    input  logic                               rstn,
    input  logic                               ifft_mode,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [0:LANES-1][WIDTH-1:0]        in_re,
    input  logic [0:LANES-1][WIDTH-1:0]        in_im,
    output logic                               out_valid,
    output logic                               out_frame_start,
    output logic [$clog2(BEATS)-1:0]           out_beat,
    output logic [0:LANES-1][WIDTH-1:0]        out_re,
    output logic [0:LANES-1][WIDTH-1:0]        out_im
);

    localparam int BW = $clog2(BEATS);
    localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};

    typedef logic [0:LANES-1][WIDTH-1:0] beat_t;
    typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   wr_beat_q, wr_beat_d;
    logic            wr_bank_q, wr_bank_d;
    logic [BW-1:0]   rd_beat_q, rd_beat_d;
    logic            rd_bank_q, rd_bank_d;
    logic [1:0]      full_q, full_d;
    logic            in_ready_q, in_ready_d;
    logic            ifft_q, ifft_d;
    logic            out_valid_q, out_valid_d;
    logic            out_fs_q, out_fs_d;
    logic [BW-1:0]   out_beat_q, out_beat_d;
    beat_t           out_re_q, out_re_d;
    beat_t           out_im_q, out_im_d;

    // Frame storage: address is {bank, beat}; contents need no reset because
    // the full flags decide what is ever read.
    beat_t           re_mem_q [2*BEATS];
    beat_t           im_mem_q [2*BEATS];

    logic            wr_acc;
    logic            wr_last;
    logic            other_full;
    beat_t           rd_re;
    beat_t           rd_im;

    assign wr_acc  = in_valid && in_ready_q;
    assign wr_last = wr_acc && (wr_beat_q == BW'(BEATS - 1));
    // The bank opposite the one being read counts as full if it completes on
    // this very edge, so a frame finishing while the previous one drains
    // still follows it without a gap.
    assign other_full = full_q[~rd_bank_q] || (wr_last && (wr_bank_q != rd_bank_q));

    assign rd_re = re_mem_q[{rd_bank_q, rd_beat_q}];
    assign rd_im = im_mem_q[{rd_bank_q, rd_beat_q}];

    // Host beat write into the current write bank.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            re_mem_q[{wr_bank_q, wr_beat_q}] <= in_re;
            im_mem_q[{wr_bank_q, wr_beat_q}] <= in_im;
        end
    end

    // Write-pointer, bank-full bookkeeping and read FSM next state.
    always_comb begin
        state_d   = state_q;
        wr_beat_d = wr_beat_q;
        wr_bank_d = wr_bank_q;
        rd_beat_d = rd_beat_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        ifft_d    = ifft_q;

        if (wr_acc) begin
            if (wr_last) begin
                full_d[wr_bank_q] = 1'b1;
                wr_bank_d         = ~wr_bank_q;
                wr_beat_d         = '0;
            end else begin
                wr_beat_d = wr_beat_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d   = SEND;
                    rd_beat_d = '0;
                    ifft_d    = ifft_mode;
                end
            end
            SEND: begin
                if (rd_beat_q == BW'(BEATS - 1)) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                    rd_beat_d         = '0;
                    if (other_full) begin
                        ifft_d = ifft_mode;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    rd_beat_d = rd_beat_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = !full_d[wr_bank_d];
    end

    // Output register stage: current read beat, conjugated with saturation when the frame is IFFT.
    always_comb begin
        out_valid_d = 1'b0;
        out_fs_d    = 1'b0;
        out_beat_d  = '0;
        out_re_d    = '0;
        out_im_d    = '0;
        if (state_q == SEND) begin
            out_valid_d = 1'b1;
            out_fs_d    = (rd_beat_q == '0);
            out_beat_d  = rd_beat_q;
            out_re_d    = rd_re;
            for (int j = 0; j < LANES; j++) begin
                if (!ifft_q) begin
                    out_im_d[j] = rd_im[j];
                end else if (rd_im[j] == SMIN) begin
                    out_im_d[j] = SMAX;
                end else begin
                    out_im_d[j] = -rd_im[j];
                end
            end
        end
    end

    // State and output registers; reset empties both banks and zeroes all outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            wr_beat_q   <= '0;
            wr_bank_q   <= 1'b0;
            rd_beat_q   <= '0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            in_ready_q  <= 1'b0;
            ifft_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_fs_q    <= 1'b0;
            out_beat_q  <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            state_q     <= state_d;
            wr_beat_q   <= wr_beat_d;
            wr_bank_q   <= wr_bank_d;
            rd_beat_q   <= rd_beat_d;
            rd_bank_q   <= rd_bank_d;
            full_q      <= full_d;
            in_ready_q  <= in_ready_d;
            ifft_q      <= ifft_d;
            out_valid_q <= out_valid_d;
            out_fs_q    <= out_fs_d;
            out_beat_q  <= out_beat_d;
            out_re_q    <= out_re_d;
            out_im_q    <= out_im_d;
        end
    end

    assign in_ready        = in_ready_q;
    assign out_valid       = out_valid_q;
    assign out_frame_start = out_fs_q;
    assign out_beat        = out_beat_q;
    assign out_re          = out_re_q;
    assign out_im          = out_im_q;

endmodule

// File: tb/tb_fft_frame_tx.sv
// Purpose: scoreboard bench for fft_frame_tx; driver pushes expected beats on accept, monitor pops on out_valid.
// Latency: checks two-cycle start latency, back-to-back continuity and out_beat wrap.
// Backpressure: driver honours in_ready, with optional random gaps on in_valid.
module tb_fft_frame_tx;

    localparam int W = 9;
    localparam int L = 16;
    localparam int B = 32;

    typedef logic [0:L-1][W-1:0] beat_t;
    typedef struct {
        beat_t re;
        beat_t im;
        int    beat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        ifft_mode = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    beat_t       in_re = '0;
    beat_t       in_im = '0;
    logic        out_valid;
    logic        out_frame_start;
    logic [4:0]  out_beat;
    beat_t       out_re;
    beat_t       out_im;

    fft_frame_tx #(.WIDTH(W), .LANES(L), .BEATS(B)) dut (
        .clk             (clk),
        .rstn            (rstn),
        .ifft_mode       (ifft_mode),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_re           (in_re),
        .in_im           (in_im),
        .out_valid       (out_valid),
        .out_frame_start (out_frame_start),
        .out_beat        (out_beat),
        .out_re          (out_re),
        .out_im          (out_im)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    int   cyc = 0;
    int   last_acc = 0;
    int   run_len = 0;
    int   max_run = 0;
    int   wraps = 0;
    int   lat = -1;
    bit   watch_stall = 1'b0;
    bit   saw_stall = 1'b0;
    logic prev_vld = 1'b0;
    logic [4:0] prev_beat = '0;

    task automatic chk(input bit ok, input string name, input string act, input string req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %s, expected %s", name, act, req);
        end
    endtask

    // Host beat generator for a numbered pattern.
    function automatic void gen(input int p, input int k, output beat_t r, output beat_t im);
        for (int j = 0; j < L; j++) begin
            int v;
            v = 16 * k + j;
            if (p == 0) begin
                r[j]  = 9'(v);
                im[j] = 9'(-v);
            end else if (p == 3) begin
                r[j] = 9'(v);
                case (j % 4)
                    0:       im[j] = 9'(-256);
                    1:       im[j] = 9'(255);
                    2:       im[j] = 9'(0);
                    default: im[j] = 9'(-1);
                endcase
            end else begin
                r[j]  = 9'(v + 37 * p);
                im[j] = 9'(5 * k - 3 * j + 11 * p);
            end
        end
    endfunction

    // Expected imaginary part; the conjugated values are only used with pattern 3.
    function automatic beat_t exp_im(input beat_t raw, input bit conj);
        beat_t e;
        e = raw;
        if (conj) begin
            for (int j = 0; j < L; j++) begin
                case (j % 4)
                    0:       e[j] = 9'(255);
                    1:       e[j] = 9'(-255);
                    2:       e[j] = 9'(0);
                    default: e[j] = 9'(1);
                endcase
            end
        end
        return e;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstn && in_valid && in_ready) last_acc <= cyc;
    end

    // Monitor: pops and compares on every valid output beat.
    always @(negedge clk) begin
        if (!rstn) begin
            run_len  = 0;
            prev_vld = 1'b0;
        end else begin
            chk(out_frame_start == (out_valid && out_beat == 5'd0), "frame_start_rule",
                $sformatf("fs=%0b vld=%0b beat=%0d", out_frame_start, out_valid, out_beat),
                "fs == vld && beat==0");
            if (out_valid) begin
                if (!prev_vld) lat = cyc - 1 - last_acc;
                run_len++;
                if (run_len > max_run) max_run = run_len;
                if (prev_vld && prev_beat == 5'd31 && out_beat == 5'd0) wraps++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "unexpected_beat", $sformatf("beat %0d re %h", out_beat, out_re), "no output");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk(out_re == mon_e.re, "out_re", $sformatf("%h", out_re), $sformatf("%h", mon_e.re));
                    chk(out_im == mon_e.im, "out_im", $sformatf("%h", out_im), $sformatf("%h", mon_e.im));
                    chk(out_beat == 5'(mon_e.beat), "out_beat",
                        $sformatf("%0d", out_beat), $sformatf("%0d", mon_e.beat));
                end
            end else begin
                run_len = 0;
                chk(out_re == '0 && out_im == '0 && out_beat == 5'd0, "idle_zero",
                    $sformatf("re %h im %h beat %0d", out_re, out_im, out_beat), "all zero");
            end
            if (watch_stall && in_valid && !in_ready) saw_stall = 1'b1;
            prev_vld  = out_valid;
            prev_beat = out_beat;
        end
    end

    task automatic send_frame(input int p, input int nbeats, input bit conj, input bit gapped);
        for (int k = 0; k < nbeats; k++) begin
            beat_t r;
            beat_t im;
            int    budget;
            bit    done;
            exp_t  e;
            gen(p, k, r, im);
            budget = 0;
            done   = 1'b0;
            while (!done) begin
                @(negedge clk);
                in_re = r;
                in_im = im;
                if (gapped && $urandom_range(1) == 0) begin
                    in_valid = 1'b0;
                end else begin
                    in_valid = 1'b1;
                    if (in_ready) begin
                        @(posedge clk);
                        e.re   = r;
                        e.im   = exp_im(im, conj);
                        e.beat = k;
                        exp_q.push_back(e);
                        #1 in_valid = 1'b0;
                        done = 1'b1;
                    end
                end
                budget++;
                if (!done && budget > 300) begin
                    chk(1'b0, "in_ready_timeout", "in_ready low 300 cycles", "accept");
                    in_valid = 1'b0;
                    done     = 1'b1;
                end
            end
        end
    endtask

    task automatic wait_out_beat(input int b);
        int n;
        n = 0;
        while (!(out_valid && out_beat == 5'(b)) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk(n < 500, "wait_out_beat", $sformatf("%0d cycles", n), $sformatf("beat %0d seen", b));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 1000, "drain", $sformatf("%0d beats left", exp_q.size()), "0 beats left");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        #1 rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk(in_ready == 1'b0 && out_valid == 1'b0 && out_frame_start == 1'b0 &&
            out_beat == 5'd0 && out_re == '0 && out_im == '0, "reset_outputs",
            $sformatf("rdy %0b vld %0b", in_ready, out_valid), "all zero");
        #2 rstn = 1'b1;
        #1 chk(in_ready == 1'b0, "ready_before_edge", $sformatf("%0b", in_ready), "0");
        @(negedge clk);
        chk(in_ready == 1'b1, "ready_after_edge", $sformatf("%0b", in_ready), "1");

        // 1: single frame, latency and ordering
        lat = -1; max_run = 0;
        send_frame(0, B, 1'b0, 1'b0);
        drain();
        chk(lat == 2, "t1_latency", $sformatf("%0d", lat), "2");
        chk(max_run == 32, "t1_run", $sformatf("%0d", max_run), "32");

        // 2 and 6: three frames back-to-back
        max_run = 0; wraps = 0; saw_stall = 1'b0; watch_stall = 1'b1;
        send_frame(1, B, 1'b0, 1'b0);
        send_frame(2, B, 1'b0, 1'b0);
        send_frame(4, B, 1'b0, 1'b0);
        drain();
        watch_stall = 1'b0;
        chk(saw_stall, "t2_ready_drop", $sformatf("%0b", saw_stall), "1");
        chk(max_run == 96, "t2_run", $sformatf("%0d", max_run), "96");
        chk(wraps == 2, "t6_wraps", $sformatf("%0d", wraps), "2");

        // 3: conjugate with saturation; mid-frame toggles take no effect
        @(negedge clk) ifft_mode = 1'b1;
        send_frame(3, B, 1'b1, 1'b0);
        wait_out_beat(5);
        ifft_mode = 1'b0;
        drain();
        send_frame(3, B, 1'b0, 1'b0);
        wait_out_beat(5);
        ifft_mode = 1'b1;
        drain();
        ifft_mode = 1'b0;

        // 4: gapped input
        lat = -1; max_run = 0;
        send_frame(0, B, 1'b0, 1'b1);
        drain();
        chk(max_run == 32, "t4_run", $sformatf("%0d", max_run), "32");
        chk(lat == 2, "t4_latency", $sformatf("%0d", lat), "2");

        // 5: reset during write beat 17 while a frame is being sent
        send_frame(5, B, 1'b0, 1'b0);
        send_frame(6, 17, 1'b0, 1'b0);
        @(negedge clk);
        chk(out_valid == 1'b1, "t5_sending", $sformatf("%0b", out_valid), "1");
        #2 rstn = 1'b0;
        #1 chk(in_ready == 1'b0 && out_valid == 1'b0 && out_frame_start == 1'b0 &&
               out_beat == 5'd0 && out_re == '0 && out_im == '0, "t5_reset_outputs",
               $sformatf("rdy %0b vld %0b re %h", in_ready, out_valid, out_re), "all zero");
        exp_q.delete();
        repeat (2) @(negedge clk);
        #2 rstn = 1'b1;
        send_frame(7, B, 1'b0, 1'b0);
        drain();
        repeat (40) @(negedge clk);
        chk(exp_q.size() == 0 && !out_valid, "t5_clean", $sformatf("%0d left", exp_q.size()), "0 left");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
